// File: rtl/er_metric_acc.sv
// Error-metric accumulator for approximate-adder characterisation: counts samples,
// errors and zero-exact results, and tracks total and maximum error distance per run.
module er_metric_acc #(
  parameter int N           = 16,
  parameter int NUM_SAMPLES = 1024,
  parameter int CW          = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    approx_sum,
  input  logic [N-1:0]    exact_sum,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   sample_count,
  output logic [CW-1:0]   err_count,
  output logic [CW-1:0]   zero_count,
  output logic [N+CW-1:0] total_ed,
  output logic [N-1:0]    max_ed
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CW-1:0] NS = CW'(NUM_SAMPLES);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   err_q, err_d;
  logic [CW-1:0]   zero_q, zero_d;
  logic [N+CW-1:0] tot_q, tot_d;
  logic [N-1:0]    max_q, max_d;

  logic [N-1:0]    ed;
  logic [N+CW:0]   tot_sum;

  // Magnitude of the difference, ordered so the subtraction never wraps.
  assign ed      = (approx_sum >= exact_sum) ? (approx_sum - exact_sum)
                                             : (exact_sum - approx_sum);
  assign tot_sum = {1'b0, tot_q} + {{(CW+1){1'b0}}, ed};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    zero_d  = zero_q;
    tot_d   = tot_q;
    max_d   = max_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          err_d   = '0;
          zero_d  = '0;
          tot_d   = '0;
          max_d   = '0;
        end
      end
      RUN: begin
        if (in_valid) begin
          cnt_d = cnt_q + CW'(1);
          if (ed != '0)        err_d  = err_q + CW'(1);
          if (exact_sum == '0) zero_d = zero_q + CW'(1);
          tot_d = tot_sum[N+CW] ? {(N+CW){1'b1}} : tot_sum[N+CW-1:0];
          if (ed > max_q)      max_d  = ed;
          if (cnt_q + CW'(1) == NS) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      zero_q  <= '0;
      tot_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
      tot_q   <= tot_d;
      max_q   <= max_d;
    end
  end

  assign in_ready     = (state_q == RUN);
  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);
  assign sample_count = cnt_q;
  assign err_count    = err_q;
  assign zero_count   = zero_q;
  assign total_ed     = tot_q;
  assign max_ed       = max_q;

endmodule

// File: tb/tb_er_metric_acc.sv
// Bench for er_metric_acc: fixed vectors, corner sequences and random runs vs a reference model.
module tb_er_metric_acc;
  localparam int N  = 16;
  localparam int NS = 4;
  localparam int CW = 32;

  logic clk = 0, rst, start, in_valid;
  logic in_ready, busy, done;
  logic [N-1:0] approx_sum, exact_sum, max_ed;
  logic [CW-1:0] sample_count, err_count, zero_count;
  logic [N+CW-1:0] total_ed;

  er_metric_acc #(.N(N), .NUM_SAMPLES(NS), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .approx_sum(approx_sum), .exact_sum(exact_sum), .busy(busy), .done(done),
    .sample_count(sample_count), .err_count(err_count), .zero_count(zero_count),
    .total_ed(total_ed), .max_ed(max_ed));

  always #5 clk = ~clk;

  typedef logic [N-1:0] vec4_t [NS];
  typedef struct {
    vec4_t a; vec4_t e;
    int err; int zero; logic [63:0] tot; logic [N-1:0] mx;
  } vec_t;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference: metrics straight from the definitions, using wide integer arithmetic.
  task automatic model(input vec4_t a, input vec4_t e, output int err, output int zero,
                       output logic [63:0] tot, output logic [N-1:0] mx);
    longint d;
    err = 0; zero = 0; tot = 0; mx = 0;
    for (int i = 0; i < NS; i++) begin
      d = longint'(a[i]) - longint'(e[i]);
      if (d < 0) d = -d;
      if (d != 0) err++;
      if (e[i] == 0) zero++;
      tot = tot + 64'(d);
      if (d > longint'(mx)) mx = N'(d);
    end
  endtask

  task automatic chk_res(input string nm, input int err, input int zero,
                         input logic [63:0] tot, input logic [N-1:0] mx);
    chk({nm, ".cnt"},   64'(sample_count), 64'(NS));
    chk({nm, ".err"},   64'(err_count), 64'(err));
    chk({nm, ".zero"},  64'(zero_count), 64'(zero));
    chk({nm, ".tot"},   64'(total_ed), tot);
    chk({nm, ".max"},   64'(max_ed), 64'(mx));
    chk({nm, ".done"},  64'(done), 1);
    chk({nm, ".busy"},  64'(busy), 0);
    chk({nm, ".ready"}, 64'(in_ready), 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".ready"}, 64'(in_ready), 0);
    chk({nm, ".busy"},  64'(busy), 0);
    chk({nm, ".done"},  64'(done), 0);
    chk({nm, ".outs"},  64'(sample_count | err_count | zero_count | max_ed) | 64'(total_ed), 0);
  endtask

  task automatic pulse_start(input string nm);
    start = 1; tick(); start = 0;
    chk({nm, ".run_busy"}, 64'(busy), 1);
    chk({nm, ".run_clr"},  64'(sample_count) | 64'(total_ed) | 64'(max_ed), 0);
  endtask

  // Feeds samples [0..last) with optional random gaps and mid-run start pulses.
  task automatic feed(input string nm, input vec4_t a, input vec4_t e, input int last,
                      input bit stall, input bit midstart);
    int i = 0, guard = 0;
    bit acc;
    while (i < last && guard < 200) begin
      if (stall && $urandom_range(1, 0) == 1) begin
        in_valid = 0; approx_sum = N'($urandom); exact_sum = N'($urandom);
      end else begin
        in_valid = 1; approx_sum = a[i]; exact_sum = e[i];
      end
      start = midstart && ($urandom_range(3, 0) == 0);
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        i++;
        chk({nm, ".latency"}, 64'(sample_count), 64'(i));
      end
      guard++;
    end
    in_valid = 0; start = 0;
    if (guard >= 200) chk({nm, ".timeout"}, 64'(i), 64'(last));
  endtask

  vec_t tv[4];
  vec4_t ra, re, zero4;
  int merr, mzero, acc_n;
  logic [63:0] mtot;
  logic [N-1:0] mmx;
  logic [63:0] snap_tot;

  initial begin
    rst = 1; start = 0; in_valid = 0; approx_sum = 0; exact_sum = 0;
    zero4 = '{default: '0};
    tv[0] = '{a: '{16'h1234, 16'h1234, 16'h1234, 16'h1234},
              e: '{16'h1234, 16'h1234, 16'h1234, 16'h1234},
              err: 0, zero: 0, tot: 64'h0, mx: 16'h0};
    tv[1] = '{a: '{16'h0010, 16'h0005, 16'h0000, 16'h0000},
              e: '{16'h0008, 16'h0009, 16'h0000, 16'hFFFF},
              err: 3, zero: 1, tot: 64'h1000B, mx: 16'hFFFF};
    tv[2] = '{a: '{16'h0000, 16'h0000, 16'h0000, 16'h0000},
              e: '{16'h0000, 16'h0000, 16'h0000, 16'h0000},
              err: 0, zero: 4, tot: 64'h0, mx: 16'h0};
    tv[3] = '{a: '{16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFF},
              e: '{16'h0000, 16'h0000, 16'h0000, 16'h0000},
              err: 4, zero: 4, tot: 64'h2FFFE, mx: 16'hFFFF};

    tick(); tick();
    chk_zero("reset");
    rst = 0;
    in_valid = 1; tick(); in_valid = 0;
    chk_zero("idle_ignores_valid");

    foreach (tv[k]) begin
      pulse_start($sformatf("vec%0d", k));
      feed($sformatf("vec%0d", k), tv[k].a, tv[k].e, NS, 0, 0);
      chk_res($sformatf("vec%0d", k), tv[k].err, tv[k].zero, tv[k].tot, tv[k].mx);
    end

    // Overrun: valid held high well past the run length.
    pulse_start("overrun");
    acc_n = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1; approx_sum = tv[1].a[acc_n % NS]; exact_sum = tv[1].e[acc_n % NS];
      if (in_ready) acc_n++;
      tick();
    end
    in_valid = 0;
    chk("overrun.accepted", 64'(acc_n), 64'(NS));
    chk_res("overrun", tv[1].err, tv[1].zero, tv[1].tot, tv[1].mx);

    // DONE holds results against traffic.
    for (int c = 0; c < 3; c++) begin
      in_valid = 1; approx_sum = 16'hFFFF; exact_sum = 0; tick();
    end
    in_valid = 0;
    chk_res("done_hold", tv[1].err, tv[1].zero, tv[1].tot, tv[1].mx);

    // Stalls with ignored mid-run start pulses.
    pulse_start("stall");
    feed("stall", tv[1].a, tv[1].e, NS, 1, 1);
    chk_res("stall", tv[1].err, tv[1].zero, tv[1].tot, tv[1].mx);

    // Reset after two samples, then a fresh run.
    pulse_start("midrst");
    feed("midrst", tv[3].a, tv[3].e, 2, 0, 0);
    rst = 1; start = 1; in_valid = 1; tick(); rst = 0; start = 0; in_valid = 0;
    chk_zero("midrst");
    pulse_start("postrst");
    feed("postrst", tv[1].a, tv[1].e, NS, 1, 0);
    chk_res("postrst", tv[1].err, tv[1].zero, tv[1].tot, tv[1].mx);

    // Rerun directly from DONE.
    pulse_start("rerun");
    feed("rerun", tv[0].a, tv[0].e, NS, 0, 0);
    chk_res("rerun", 0, 0, 64'h0, 16'h0);

    // Random runs, biased toward extreme operands.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NS; i++) begin
        case ($urandom_range(3, 0))
          0: begin ra[i] = 16'hFFFF; re[i] = 16'h0; end
          1: begin ra[i] = N'($urandom); re[i] = ra[i]; end
          2: begin ra[i] = N'($urandom); re[i] = 16'h0; end
          default: begin ra[i] = N'($urandom); re[i] = N'($urandom); end
        endcase
      end
      model(ra, re, merr, mzero, mtot, mmx);
      pulse_start($sformatf("rnd%0d", r));
      feed($sformatf("rnd%0d", r), ra, re, NS, 1, 1);
      chk_res($sformatf("rnd%0d", r), merr, mzero, mtot, mmx);
    end

    snap_tot = 64'(total_ed);
    rst = 1; tick(); rst = 0;
    chk_zero("final_rst");
    if (snap_tot == 0) chk("zero4_model", 64'(zero4[0]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/er_metric_acc.md
ER_METRIC_ACC -- requirements
Module: er_metric_acc

Interface
REQ-001 SHALL have parameter N, default 16, operand/sum width of the adder under test.
REQ-002 SHALL have parameter NUM_SAMPLES, default 1024, sample pairs per measurement run; legal range 1 to 2^CW-1.
REQ-003 SHALL have parameter CW, default 32, width of all count outputs.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, single-cycle pulse that begins a new run.
REQ-007 SHALL have port in_valid, input, 1, upstream sample pair is present.
REQ-008 SHALL have port in_ready, output, 1, block accepts a sample this cycle.
REQ-009 SHALL have port approx_sum, input, N, approximate adder sum.
REQ-010 SHALL have port exact_sum, input, N, exact sum (A+B mod 2^N).
REQ-011 SHALL have port busy, output, 1, run in progress.
REQ-012 SHALL have port done, output, 1, run complete and results stable.
REQ-013 SHALL have port sample_count, output, CW, samples accepted this run.
REQ-014 SHALL have port err_count, output, CW, samples with approx_sum != exact_sum.
REQ-015 SHALL have port zero_count, output, CW, samples with exact_sum == 0 (MRED denominator exclusions).
REQ-016 SHALL have port total_ed, output, N+CW, sum of error distances.
REQ-017 SHALL have port max_ed, output, N, largest error distance seen.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE.
REQ-019 IDLE: start=1 -> clear all counters/accumulators, go RUN next cycle.
REQ-020 RUN: in_ready=1, busy=1; a sample is accepted only when in_valid=1 and in_ready=1.
REQ-021 Per accepted sample, error distance ed = |approx_sum - exact_sum| computed as unsigned N-bit magnitude, no wrap (e.g. approx 0x0000, exact 0xFFFF -> ed 0xFFFF).
REQ-022 Per accepted sample: sample_count+1; err_count+1 if ed!=0; zero_count+1 if exact_sum==0; total_ed += ed zero-extended; max_ed = max(max_ed, ed).
REQ-023 All outputs SHALL reflect an accepted sample in the cycle after acceptance (one-cycle latency, registered).
REQ-024 When the accepted sample makes sample_count equal NUM_SAMPLES, FSM SHALL go DONE next cycle; in_ready SHALL be 0 in that next cycle (no sample beyond NUM_SAMPLES accepted).
REQ-025 DONE: done=1, busy=0, in_ready=0, all result outputs held constant.
REQ-026 DONE: start=1 -> clear results, go RUN (back-to-back runs allowed).
REQ-027 start in RUN SHALL be ignored.
REQ-028 in_valid=0 in RUN SHALL stall with no state change; gaps of any length allowed.
REQ-029 total_ed SHALL saturate at all-ones rather than wrap.
REQ-030 In IDLE, in_ready=0, busy=0, done=0; inputs other than start/rst ignored.

Reset
REQ-031 rst=1 at a clock edge SHALL, in any state including mid-run, force IDLE and zero every output (in_ready, busy, done, all counts, total_ed, max_ed).
REQ-032 rst SHALL take priority over start and in_valid in the same cycle.

Verification (NUM_SAMPLES=4, N=16)
REQ-033 Exact run: start, 4 samples approx=exact=0x1234 -> done=1, sample_count=4, err_count=0, total_ed=0, max_ed=0, zero_count=0.
REQ-034 Mixed run: pairs (0x0010,0x0008),(0x0005,0x0009),(0x0000,0x0000),(0x0000,0xFFFF) -> err_count=3, total_ed=0x1000B, max_ed=0xFFFF, zero_count=1.
REQ-035 Backpressure/overrun: in_valid held 1 for 10 cycles -> exactly 4 accepted, in_ready=0 from cycle after 4th acceptance, done=1.
REQ-036 Stalls: in_valid toggled 1/0 randomly -> results equal same 4 samples without gaps; start pulsed mid-run ignored.
REQ-037 Reset mid-run: rst after 2 samples -> next cycle IDLE, all outputs 0; subsequent start+4 samples gives fresh correct results.
REQ-038 Rerun: start in DONE -> results cleared next cycle, second run results independent of first.
